// File: rtl/rep_window_ctrl.sv
// Sequencer for a consecutive-repetition counter evaluating "a[*min:max] ##1 b".
// A start in IDLE latches the window bounds. The controller then counts
// consecutive cycles of a and issues exactly one verdict, either match or fail,
// unless the evaluation is aborted. All outputs come from registers.
module rep_window_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] min_rep,
    input  logic [W-1:0] max_rep,
    input  logic         abort,
    input  logic         a,
    input  logic         b,
    output logic         busy,
    output logic         match,
    output logic         fail,
    output logic         bad_cfg,
    output logic [W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_min;
    logic [W-1:0] r_max;
    logic [W-1:0] r_count;
    logic         r_busy;
    logic         r_match;
    logic         r_fail;
    logic         r_bad_cfg;

    logic [W-1:0] w_min_next;
    logic [W-1:0] w_max_next;
    logic [W-1:0] w_count_next;
    logic         w_match_next;
    logic         w_fail_next;
    logic         w_bad_cfg_next;
    logic         w_busy_next;

    // State, latched window bounds and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_min     <= '0;
            r_max     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_match   <= 1'b0;
            r_fail    <= 1'b0;
            r_bad_cfg <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_min     <= w_min_next;
            r_max     <= w_max_next;
            r_count   <= w_count_next;
            r_busy    <= w_busy_next;
            r_match   <= w_match_next;
            r_fail    <= w_fail_next;
            r_bad_cfg <= w_bad_cfg_next;
        end
    end

    // Next-state and next-output logic; RUN rules are evaluated in priority order.
    always_comb begin
        w_state_next   = r_state;
        w_min_next     = r_min;
        w_max_next     = r_max;
        w_count_next   = r_count;
        w_match_next   = 1'b0;
        w_fail_next    = 1'b0;
        w_bad_cfg_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_count_next = '0;
                if (start) begin
                    w_min_next = min_rep;
                    w_max_next = max_rep;
                    if (min_rep > max_rep) begin
                        // An empty window can never match, so the verdict is
                        // issued without spending a RUN cycle.
                        w_state_next   = ST_DONE;
                        w_fail_next    = 1'b1;
                        w_bad_cfg_next = 1'b1;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if ((r_count >= r_min) && b) begin
                    // First match: b ends the sequence even if a is also high.
                    w_state_next = ST_DONE;
                    w_match_next = 1'b1;
                end else if ((r_count < r_max) && a) begin
                    w_count_next = r_count + W'(1);
                end else begin
                    // The count stays at or below max, so the counter never wraps.
                    w_state_next = ST_DONE;
                    w_fail_next  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign busy    = r_busy;
    assign match   = r_match;
    assign fail    = r_fail;
    assign bad_cfg = r_bad_cfg;
    assign count   = r_count;

endmodule

// File: tb/tb_rep_window_ctrl.sv
// Randomized self-checking bench for rep_window_ctrl. It uses a reference model
// built on one observation: in RUN cycle i of an evaluation, the repetition
// count equals i, because every cycle that does not end the evaluation adds
// exactly one repetition.
module tb_rep_window_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] min_rep;
    logic [7:0] max_rep;
    logic       abort;
    logic       a;
    logic       b;
    logic       busy;
    logic       match;
    logic       fail;
    logic       bad_cfg;
    logic [7:0] count;

    int checks;
    int errors;

    // Per-RUN-cycle stimulus for the current evaluation.
    logic sa [0:299];
    logic sb [0:299];
    logic sx [0:299];

    rep_window_ctrl #(.W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .min_rep (min_rep),
        .max_rep (max_rep),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .match   (match),
        .fail    (fail),
        .bad_cfg (bad_cfg),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model. kind: 0 match, 1 fail, 2 abort, 3 bad config.
    // idx is the RUN cycle that decides the outcome; the count at that cycle is idx.
    function automatic void predict(input int mn, input int mx, output int kind, output int idx);
        kind = 1;
        idx  = 0;
        if (mn > mx) begin
            kind = 3;
            return;
        end
        for (int i = 0; i < 300; i++) begin
            idx = i;
            if (sx[i]) begin
                kind = 2;
                return;
            end
            if (i >= mn && sb[i]) begin
                kind = 0;
                return;
            end
            if (!(i < mx && sa[i])) begin
                kind = 1;
                return;
            end
        end
    endfunction

    function automatic void clear_stim();
        for (int i = 0; i < 300; i++) begin
            sa[i] = 1'b0;
            sb[i] = 1'b0;
            sx[i] = 1'b0;
        end
    endfunction

    // Start one evaluation, apply the stimulus arrays, and check every cycle.
    task automatic run_eval(input int mn, input int mx, input string name);
        int         kind;
        int         idx;
        logic [11:0] got;
        logic [11:0] exp;
        string      vname;
        predict(mn, mx, kind, idx);

        start   = 1'b1;
        min_rep = 8'(mn);
        max_rep = 8'(mx);
        a       = 1'b0;
        b       = 1'b0;
        abort   = 1'b0;
        step();
        start = 1'b0;

        if (kind == 3) begin
            got = {busy, match, fail, bad_cfg, count};
            exp = {1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s badcfg-verdict: got busy/match/fail/bad/count=%h required %h", name, got, exp);
            end
        end else begin
            got = {busy, match, fail, bad_cfg, count};
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s run-entry: got busy/match/fail/bad/count=%h required %h", name, got, exp);
            end
            for (int i = 0; i <= idx; i++) begin
                a     = sa[i];
                b     = sb[i];
                abort = sx[i];
                // start and new bounds must be ignored outside IDLE.
                start   = 1'($urandom_range(0, 1));
                min_rep = 8'($urandom_range(0, 255));
                max_rep = 8'($urandom_range(0, 255));
                step();
                got = {busy, match, fail, bad_cfg, count};
                if (i < idx)        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1)};
                else if (kind == 0) exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'(i)};
                else if (kind == 1) exp = {1'b1, 1'b0, 1'b1, 1'b0, 8'(i)};
                else                exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s run-cycle-%0d: got busy/match/fail/bad/count=%h required %h", name, i, got, exp);
                end
            end
        end

        // The DONE cycle, or the IDLE cycle after an abort, returns to IDLE with everything clear.
        start = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        got = {busy, match, fail, bad_cfg, count};
        exp = 12'd0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s back-to-idle: got busy/match/fail/bad/count=%h required %h", name, got, exp);
        end

        case (kind)
            0: vname = "match";
            1: vname = "fail";
            2: vname = "abort";
            default: vname = "bad_cfg";
        endcase
        $display("txn %s min=%0d max=%0d -> %s count=%0d", name, mn, mx, vname, (kind == 3) ? 0 : idx);
    endtask

    // Monitor the invariants on every sampled cycle.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            checks++;
            if ((match && fail) || (bad_cfg && !fail)) begin
                errors++;
                $display("FAIL invariant: got match=%b fail=%b bad_cfg=%b required exclusive verdict, bad_cfg only with fail", match, fail, bad_cfg);
            end
        end
    end

    task automatic test_reset();
        logic [11:0] got;
        rst_n = 1'b0;
        start = 1'b0; min_rep = '0; max_rep = '0; abort = 1'b0; a = 1'b0; b = 1'b0;
        #1;
        got = {busy, match, fail, bad_cfg, count};
        checks++;
        if (got !== 12'd0) begin
            errors++;
            $display("FAIL reset-state: got %h required 000", got);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        got = {busy, match, fail, bad_cfg, count};
        checks++;
        if (got !== 12'd0) begin
            errors++;
            $display("FAIL post-reset-idle: got %h required 000", got);
        end
    endtask

    task automatic test_empty();
        clear_stim(); sb[0] = 1'b1;
        run_eval(0, 0, "empty_match");
        clear_stim(); sa[0] = 1'b1;
        run_eval(0, 0, "empty_fail");
    endtask

    task automatic test_window();
        clear_stim(); sa[0] = 1; sa[1] = 1; sa[2] = 1; sb[3] = 1;
        run_eval(2, 4, "window_match");
        clear_stim(); sa[0] = 1; sb[1] = 1;
        run_eval(2, 4, "window_early_b");
    endtask

    task automatic test_overrun();
        clear_stim(); for (int i = 0; i < 4; i++) sa[i] = 1;
        run_eval(1, 3, "overrun");
        clear_stim(); for (int i = 0; i < 300; i++) sa[i] = 1;
        run_eval(0, 255, "max_no_wrap");
        clear_stim(); for (int i = 0; i < 300; i++) sa[i] = 1; sb[255] = 1;
        run_eval(255, 255, "max_match");
    endtask

    task automatic test_bad_cfg_priority();
        clear_stim();
        run_eval(5, 2, "bad_cfg");
        clear_stim(); for (int i = 0; i < 10; i++) begin sa[i] = 1; sb[i] = 1; end
        run_eval(1, 4, "a_and_b");
    endtask

    task automatic test_abort();
        clear_stim(); sa[0] = 1; sa[1] = 1; sa[2] = 1; sx[2] = 1;
        run_eval(3, 6, "abort_cnt2");
        clear_stim(); sb[0] = 1;
        run_eval(0, 3, "after_abort");
    endtask

    task automatic test_mid_reset();
        logic [11:0] got;
        start = 1'b1; min_rep = 8'd2; max_rep = 8'd6;
        step();
        start = 1'b0; a = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        got = {busy, match, fail, bad_cfg, count};
        checks++;
        if (got !== 12'd0) begin
            errors++;
            $display("FAIL mid-run-reset: got %h required 000", got);
        end
        a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("txn mid_reset min=2 max=6 -> reset count=0");
        clear_stim(); sa[0] = 1; sb[1] = 1;
        run_eval(1, 2, "after_reset");
    endtask

    task automatic test_random();
        int mn;
        int mx;
        for (int t = 0; t < 40; t++) begin
            clear_stim();
            mn = $urandom_range(0, 6);
            mx = $urandom_range(0, 7);
            for (int i = 0; i < 300; i++) begin
                sa[i] = ($urandom_range(0, 9) < 8);
                sb[i] = ($urandom_range(0, 9) < 3);
                sx[i] = ($urandom_range(0, 29) == 0);
            end
            run_eval(mn, mx, "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_empty();
        test_window();
        test_overrun();
        test_bad_cfg_priority();
        test_abort();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
